fibonacci_stream: RTL and testbench
===================================

// Module: fibonacci_stream
// PURPOSE
//  Parametrised successor to the 8-bit Fibonacci counter. Generates a programmable-length
//  Fibonacci-type sequence (run-time seeds, so Lucas etc.) of WIDTH bits, one term per
//  divider tick, on a valid/ready stream. Adds start/stop control, carry-based overflow
//  detection with wrap or stop-on-overflow mode, term index and done pulse.
// PARAMETERS
//  WIDTH       16   term width in bits (>=2)
//  CNT_W       8    width of num_terms / out_index
//  DECIMATION  16   clk cycles per generation tick (>=1; 1 = every cycle)
// PORTS
//  clk        in   1      single clock
//  reset      in   1      synchronous, active-high
//  start      in   1      pulse; accepted only in IDLE; loads seeds/num_terms/mode_stop
//  stop       in   1      abort: return to IDLE, drop pending term
//  seed_a     in   WIDTH  term(-1)
//  seed_b     in   WIDTH  term(0), first term emitted
//  num_terms  in   CNT_W  number of terms to emit
//  mode_stop  in   1      0 = wrap modulo 2^WIDTH; 1 = end run before first overflowed term
//  out_data   out  WIDTH  current term
//  out_index  out  CNT_W  index of out_data, 0-based
//  out_valid  out  1      out_data/out_index valid
//  out_ready  in   1      sink accepts when out_valid & out_ready
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse at end of run (completed or overflow-stopped)
//  overflow   out  1      sticky: some emitted/suppressed term overflowed; cleared by start
// BEHAVIOUR
//  - Reset: state IDLE, a=0, b=0, idx=0, all outputs 0; divider phase cleared.
//  - States: IDLE, RUN, FINISH.
//  - IDLE: out_valid=0. start & !stop -> capture a=seed_a, b=seed_b, idx=0, overflow=0,
//    latch num_terms/mode_stop, restart divider phase, go RUN. start&stop: start ignored.
//    num_terms==0: go FINISH directly, no terms emitted.
//  - Tick: divider pulses once every DECIMATION cycles; first pulse DECIMATION cycles after
//    the start cycle (start at cycle 0 -> first out_valid rises at cycle DECIMATION).
//  - RUN, tick with no pending term: out_data<=b, out_index<=idx, out_valid<=1;
//    {c,s}=a+b (WIDTH+1 bits); a<=b; b<=s; b_ovf<=c; idx<=idx+1.
//  - Tick while out_valid & !out_ready: tick dropped; sequence stalls, no term lost or skipped.
//  - Handshake: out_data/out_index stable while out_valid & !out_ready; out_valid falls the
//    cycle after acceptance unless a tick re-asserts it that same edge (DECIMATION=1: back-to-back).
//  - Overflow: the term loaded from a carried sum has b_ovf=1. Emitting it sets overflow
//    (wrap mode, value = sum mod 2^WIDTH). In stop mode it is never emitted: on that tick set
//    overflow, go FINISH. Carries from later sums of wrapped values also flag.
//  - Completion: acceptance of term idx=num_terms-1 -> FINISH.
//  - FINISH: done=1 for exactly one cycle, out_valid=0, -> IDLE.
//  - stop in RUN/FINISH: next cycle IDLE, out_valid=0, no done pulse; overflow keeps its value.
//  - start while busy: ignored. reset anywhere: reset values next cycle.
// STRUCTURE
//  - fib_pkg: state encoding (IDLE/RUN/FINISH), localparam helpers for CNT_W checks.
//  - Sub-module: clk_division (parameter DECIMATION) producing clken; its reset driven by
//    reset | start_accept so tick phase aligns to start. Core FSM/datapath in this module.
// TESTING
//  1. WIDTH=8,DEC=1,seeds 0/1,num_terms=13,ready=1 -> 1,1,2,3,5,8,13,21,34,55,89,144,233,
//     idx 0..12 on consecutive cycles, done pulse, overflow=0.
//  2. Same, num_terms=15, mode_stop=0 -> idx13=121, idx14=98; overflow rises with idx13.
//  3. Same, num_terms=15, mode_stop=1 -> last term 233 idx12, done pulse, overflow=1, no idx13.
//  4. DEC=4, ready low 20 cycles after first valid -> out_data=1 idx0 held; next term 1 idx1
//     on first tick after acceptance; no skipped indices.
//  5. Seeds 2/1 (Lucas), num_terms=6 -> 1,3,4,7,11,18; first valid exactly 4 cycles after start.
//  6. stop at idx5 (valid pending), then reset mid-run of new start -> out_valid=0 next cycle,
//     busy=0, no done; fresh start replays from seeds at idx0; start with num_terms=0 -> done only.

Source files
------------

// File: rtl/fibonacci_stream_pkg.sv
// fibonacci_stream_pkg: shared state encoding and sizing helpers for the Fibonacci stream generator.
package fibonacci_stream_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_t;
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fibonacci_stream_if.sv
// fibonacci_stream_if: valid/ready term stream carrying the term value and its 0-based index.
interface fibonacci_stream_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_index;
  logic             out_valid;
  logic             out_ready;
  modport master (output out_data, output out_index, output out_valid, input out_ready);
  modport slave (input out_data, input out_index, input out_valid, output out_ready);
endinterface

// File: rtl/fibonacci_stream_clk_division.sv
// clk_division: one-cycle clken every DECIMATION cycles, first pulse DECIMATION-1 cycles after rst.
module clk_division
  import fibonacci_stream_pkg::*;
#(
  parameter int DECIMATION = 16
) (
  input  logic clk,
  input  logic rst,
  output logic clken
);
  localparam int CW = cnt_bits(DECIMATION);
  localparam logic [CW-1:0] LAST = CW'(DECIMATION - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign clken = cnt_q == LAST;
  always_comb cnt_d = clken ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/fibonacci_stream.sv
// fibonacci_stream: programmable-length, run-time-seeded Fibonacci-type sequence on a valid/ready stream.
module fibonacci_stream
  import fibonacci_stream_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 8,
  parameter int DECIMATION = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [WIDTH-1:0]     seed_a,
  input  logic [WIDTH-1:0]     seed_b,
  input  logic [CNT_W-1:0]     num_terms,
  input  logic                 mode_stop,
  fibonacci_stream_if.master   out,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [CNT_W-1:0] idx_q, idx_d, n_q, n_d, index_q, index_d;
  logic             bovf_q, bovf_d, mode_q, mode_d, valid_q, valid_d, ovf_q, ovf_d;
  logic [WIDTH:0]   sum;
  logic             tick, start_acc, accept, last;
  assign start_acc = state_q == ST_IDLE && start && !stop;
  // Divider restarts on an accepted start so the first term lands DECIMATION cycles later.
  clk_division #(.DECIMATION(DECIMATION)) u_div (
    .clk   (clk),
    .rst   (reset | start_acc),
    .clken (tick)
  );
  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  assign accept = valid_q && out.out_ready;
  assign last   = accept && index_q == n_q - 1'b1;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    bovf_d  = bovf_q;
    idx_d   = idx_q;
    n_d     = n_q;
    mode_d  = mode_q;
    data_d  = data_q;
    index_d = index_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (start_acc) begin
          a_d     = seed_a;
          b_d     = seed_b;
          bovf_d  = 1'b0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          n_d     = num_terms;
          mode_d  = mode_stop;
          state_d = num_terms == '0 ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (last) begin
          valid_d = 1'b0;
          state_d = ST_FINISH;
        end else if (tick && (!valid_q || accept)) begin
          // A term built from a carried sum is withheld entirely in stop mode.
          if (mode_q && bovf_q) begin
            ovf_d   = 1'b1;
            valid_d = 1'b0;
            state_d = ST_FINISH;
          end else begin
            data_d  = b_q;
            index_d = idx_q;
            valid_d = 1'b1;
            ovf_d   = ovf_q | bovf_q;
            a_d     = b_q;
            b_d     = sum[WIDTH-1:0];
            bovf_d  = sum[WIDTH];
            idx_d   = idx_q + 1'b1;
          end
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      bovf_q  <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bovf_q  <= bovf_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end
  assign out.out_data  = data_q;
  assign out.out_index = index_q;
  assign out.out_valid = valid_q;
  assign busy          = state_q != ST_IDLE;
  assign done          = state_q == ST_FINISH;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_fibonacci_stream.sv
// tb_fibonacci_stream: scoreboard bench for two 8-bit generators, one ticking every cycle, one every 4.
module tb_fibonacci_stream;
  logic       clk = 1'b0;
  logic       reset, start1, start4, stop, mode;
  logic [7:0] seed_a, seed_b, num;
  logic       busy1, done1, ovf1, busy4, done4, ovf4;
  logic [16:0] q1[$], q4[$];
  int n_chk = 0, n_fail = 0, mon_chk = 0, mon_fail = 0, dn1 = 0, dn4 = 0;
  int fib8 [15] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
  fibonacci_stream_if #(.WIDTH(8), .CNT_W(8)) s1 ();
  fibonacci_stream_if #(.WIDTH(8), .CNT_W(8)) s4 ();
  fibonacci_stream #(.WIDTH(8), .CNT_W(8), .DECIMATION(1)) d1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop), .seed_a(seed_a), .seed_b(seed_b),
    .num_terms(num), .mode_stop(mode), .out(s1.master), .busy(busy1), .done(done1), .overflow(ovf1));
  fibonacci_stream #(.WIDTH(8), .CNT_W(8), .DECIMATION(4)) d4 (
    .clk(clk), .reset(reset), .start(start4), .stop(stop), .seed_a(seed_a), .seed_b(seed_b),
    .num_terms(num), .mode_stop(mode), .out(s4.master), .busy(busy4), .done(done4), .overflow(ovf4));
  always #5 clk = ~clk;
  // Monitor: every accepted term is popped from its queue and compared as {overflow, index, data}.
  always @(negedge clk) begin
    logic [16:0] e;
    if (s1.out_valid && s1.out_ready) begin
      mon_chk++;
      if (q1.size() == 0) begin
        mon_fail++;
        $display("FAIL d1 unexpected term: got idx=%0d data=%0d, required no term", s1.out_index, s1.out_data);
      end else begin
        e = q1.pop_front();
        if ({ovf1, s1.out_index, s1.out_data} !== e) begin
          mon_fail++;
          $display("FAIL d1 term: got ovf=%0d idx=%0d data=%0d, required ovf=%0d idx=%0d data=%0d",
                   ovf1, s1.out_index, s1.out_data, e[16], e[15:8], e[7:0]);
        end
      end
    end
    if (s4.out_valid && s4.out_ready) begin
      mon_chk++;
      if (q4.size() == 0) begin
        mon_fail++;
        $display("FAIL d4 unexpected term: got idx=%0d data=%0d, required no term", s4.out_index, s4.out_data);
      end else begin
        e = q4.pop_front();
        if ({ovf4, s4.out_index, s4.out_data} !== e) begin
          mon_fail++;
          $display("FAIL d4 term: got ovf=%0d idx=%0d data=%0d, required ovf=%0d idx=%0d data=%0d",
                   ovf4, s4.out_index, s4.out_data, e[16], e[15:8], e[7:0]);
        end
      end
    end
    if (done1) dn1++;
    if (done4) dn4++;
  end
  task automatic chk(input string name, input int got, input int req);
    n_chk++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input bit four, input int n, input int ovf_from, input int vals [15]);
    for (int i = 0; i < n; i++) begin
      logic [16:0] e;
      e = {i >= ovf_from, 8'(i), 8'(vals[i])};
      if (four) q4.push_back(e);
      else q1.push_back(e);
    end
  endtask
  task automatic go(input bit four, input int a, input int b, input int n, input bit m, output int lat);
    seed_a = 8'(a);
    seed_b = 8'(b);
    num = 8'(n);
    mode = m;
    if (four) start4 = 1'b1;
    else start1 = 1'b1;
    cyc(1);
    start1 = 1'b0;
    start4 = 1'b0;
    lat = 0;
    while (!(four ? s4.out_valid : s1.out_valid) && lat < 20) begin
      cyc(1);
      lat++;
    end
  endtask
  initial begin
    int lat, d0, n;
    bit held;
    int lucas [15] = '{1, 3, 4, 7, 11, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    reset = 1'b1;
    {start1, start4, stop, mode} = '0;
    {seed_a, seed_b, num} = '0;
    s1.out_ready = 1'b1;
    s4.out_ready = 1'b1;
    cyc(3);
    chk("reset valid", s1.out_valid, 0);
    chk("reset busy/done/ovf", {busy1, done1, ovf1, busy4, done4, ovf4}, 0);
    chk("reset data/index", {s4.out_data, s4.out_index}, 0);
    reset = 1'b0;
    cyc(1);
    // 1: 13 terms, every cycle, no overflow
    d0 = dn1;
    push(1'b0, 13, 99, fib8);
    go(1'b0, 0, 1, 13, 1'b0, lat);
    chk("t1 latency", lat, 1);
    cyc(12);
    chk("t1 idx12 consecutive", {s1.out_valid, s1.out_index, s1.out_data}, {1'b1, 8'd12, 8'd233});
    cyc(8);
    chk("t1 done", dn1 - d0, 1);
    chk("t1 overflow", ovf1, 0);
    chk("t1 drained", q1.size(), 0);
    // 2: wrap mode, overflow sticky from idx13
    d0 = dn1;
    push(1'b0, 15, 13, fib8);
    go(1'b0, 0, 1, 15, 1'b0, lat);
    cyc(25);
    chk("t2 done", dn1 - d0, 1);
    chk("t2 overflow", ovf1, 1);
    chk("t2 drained", q1.size(), 0);
    // 3: stop mode, run ends before overflowed term
    d0 = dn1;
    push(1'b0, 13, 99, fib8);
    go(1'b0, 0, 1, 15, 1'b1, lat);
    cyc(25);
    chk("t3 done", dn1 - d0, 1);
    chk("t3 overflow", ovf1, 1);
    chk("t3 busy", busy1, 0);
    chk("t3 drained", q1.size(), 0);
    // 4: backpressure on DEC=4
    d0 = dn4;
    s4.out_ready = 1'b0;
    push(1'b1, 5, 99, fib8);
    go(1'b1, 0, 1, 5, 1'b0, lat);
    chk("t4 latency", lat, 4);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      held &= s4.out_valid && s4.out_data == 8'd1 && s4.out_index == 8'd0;
      cyc(1);
    end
    chk("t4 held idx0", held, 1);
    s4.out_ready = 1'b1;
    cyc(1);
    n = 0;
    while (!(s4.out_valid && s4.out_index == 8'd1) && n < 10) begin
      cyc(1);
      n++;
    end
    chk("t4 next term within one tick", n < 4, 1);
    cyc(30);
    chk("t4 done", dn4 - d0, 1);
    chk("t4 drained", q4.size(), 0);
    // 5: Lucas seeds
    d0 = dn4;
    push(1'b1, 6, 99, lucas);
    go(1'b1, 2, 1, 6, 1'b0, lat);
    chk("t5 latency", lat, 4);
    cyc(30);
    chk("t5 done", dn4 - d0, 1);
    chk("t5 overflow", ovf4, 0);
    chk("t5 drained", q4.size(), 0);
    // 6: stop with term pending, reset mid-run, replay, zero-length run
    d0 = dn4;
    push(1'b1, 5, 99, fib8);
    go(1'b1, 0, 1, 20, 1'b0, lat);
    n = 0;
    while (!(s4.out_valid && s4.out_index == 8'd5) && n < 60) begin
      cyc(1);
      n++;
    end
    chk("t6 reached idx5", s4.out_valid && s4.out_index == 8'd5, 1);
    s4.out_ready = 1'b0;
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("t6 stop valid/busy", {s4.out_valid, busy4}, 0);
    cyc(5);
    chk("t6 stop no done", dn4 - d0, 0);
    chk("t6 drained", q4.size(), 0);
    go(1'b1, 0, 1, 20, 1'b0, lat);
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t6 reset valid/busy/ovf", {s4.out_valid, busy4, ovf4}, 0);
    chk("t6 reset data/index", {s4.out_data, s4.out_index}, 0);
    chk("t6 reset no done", dn4 - d0, 0);
    s4.out_ready = 1'b1;
    push(1'b1, 3, 99, fib8);
    go(1'b1, 0, 1, 3, 1'b0, lat);
    chk("t6 replay latency", lat, 4);
    cyc(20);
    chk("t6 replay done", dn4 - d0, 1);
    chk("t6 replay drained", q4.size(), 0);
    num = 8'd0;
    start4 = 1'b1;
    cyc(1);
    start4 = 1'b0;
    chk("t6 zero-length done", {done4, busy4, s4.out_valid}, 3'b110);
    cyc(5);
    chk("t6 zero-length single done", dn4 - d0, 2);
    chk("t6 zero-length idle", busy4, 0);
    n_chk += mon_chk;
    n_fail += mon_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
